// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Two-port round-robin arbiter and sequencer in front of a single-port
//   synchronous RAM (one-edge access, read data valid after the access edge).
//   Each transaction takes three clocks: IDLE (grant) -> ACCESS (RAM acts on
//   the closing edge) -> CAPTURE (read data sampled, done pulsed) -> IDLE.
//
// Ports
//   clk, clear_n                 clock (posedge), asynchronous active-low reset
//   req/we/addr/wdata 0 and 1    requester inputs, held stable until done
//   done0/done1                  one-cycle completion pulses (never together)
//   rdata0/rdata1                per-port read data, updated on read completion
//   busy, grant_id               sequencer activity and owning port
//   mem_addr/read/write/wdata    RAM command outputs
//   mem_rdata                    RAM read data, only sampled in CAPTURE
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              done0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done1,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic              grant_id,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                done0_q, done0_d;
  logic                done1_q, done1_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic                busy_q, busy_d;
  logic                grant_id_q, grant_id_d;
  logic                last_grant_q, last_grant_d;
  logic                op_we_q, op_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic                sel;
  logic                sel_we;

  // Port choice: a lone requester wins; on a tie the port that did not win
  // last time goes next.
  always_comb begin
    sel = 1'b0;
    if (req0 && req1) begin
      sel = ~last_grant_q;
    end else if (req1) begin
      sel = 1'b1;
    end
    sel_we = sel ? we1 : we0;
  end

  always_comb begin
    state_d      = state_q;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    op_we_d      = op_we_q;
    mem_addr_d   = mem_addr_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_wdata_d  = mem_wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          grant_id_d   = sel;
          last_grant_d = sel;
          op_we_d      = sel_we;
          mem_addr_d   = sel ? addr1 : addr0;
          mem_wdata_d  = sel ? wdata1 : wdata0;
          mem_read_d   = ~sel_we;
          mem_write_d  = sel_we;
          state_d      = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // The RAM acts on this closing edge; drop the strobes but keep the
        // address so the command is exactly one cycle wide.
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        state_d     = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (!op_we_q) begin
          if (grant_id_q) begin
            rdata1_d = mem_rdata;
          end else begin
            rdata0_d = mem_rdata;
          end
        end
        done0_d = ~grant_id_q;
        done1_d = grant_id_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d     = ST_IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q      <= ST_IDLE;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      busy_q       <= 1'b0;
      grant_id_q   <= 1'b0;
      last_grant_q <= 1'b1;   // port 0 wins the first tie
      op_we_q      <= 1'b0;
      mem_addr_q   <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      busy_q       <= busy_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      op_we_q      <= op_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign done0     = done0_q;
  assign done1     = done1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign busy      = busy_q;
  assign grant_id  = grant_id_q;
  assign mem_addr  = mem_addr_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_wdata = mem_wdata_q;

endmodule
